m68k_bus_initiator: RTL and testbench
=====================================

# m68k_bus_initiator

Bus-master sequencer that drives the 68000-side bus (AS_N, UDS_N, LDS_N, RW, FC, A, data) toward the glue MCU and decodes its responses (DTACK_N, BERR_N, VPA_N). It serves as the CPU-cycle generator for bus-level simulation and as the initiator core for any on-chip master. It implements the normal asynchronous cycle, 6800-style VPA/VMA/E cycles, and autovectored interrupt acknowledge.

## Interface
Parameters:
- TIMEOUT_TICKS, 250: maximum S4 wait ticks before the cycle ends with an error.
- VMA_AT, 8: E-phase count at which VMA_N asserts.

Ports:
- clk32  in  1  system clock; the only clock.
- res  in  1  reset, asynchronous, active-high.
- cmd_req  in  1  command request, level; held until ack.
- cmd_we  in  1  1 = write.
- cmd_iack  in  1  interrupt-acknowledge cycle; level in cmd_addr[3:1].
- cmd_addr  in  23  word address [23:1].
- cmd_ds  in  2  [1] = UDS, [0] = LDS.
- cmd_fc  in  3  function code; ignored for iack.
- cmd_wdata  in  16  write data.
- ack  out  1  one-clk32 completion pulse.
- rsp_rdata  out  16  read or vector data; valid with ack.
- rsp_err  out  1  BERR or timeout; valid with ack.
- rsp_auto  out  1  completion came through the VPA path; valid with ack.
- AS_N, UDS_N, LDS_N, RW  out  1  bus strobes.
- FC  out  3  function code.
- A  out  23  address bus.
- DOUT  out  16  write data.
- DOE  out  1  data output enable.
- DIN  in  16  read data.
- DTACK_N, BERR_N, VPA_N  in  1  responder handshake signals.
- VMA_N  out  1  valid memory address for 6800-style cycles.
- E  out  1  6800 E clock.

## Operation
- The phase bit `ph` toggles every clk32. Each clk32 edge with ph==1 is a **tick** (one 68000 half-clock, 62.5 ns).
- The E-phase counter `ecnt` counts 0..19 per tick and wraps, free-running from reset.
  - E = (ecnt ≥ 12): 6 CPU clocks low, 4 high.
- States: IDLE, S0–S7, EWAIT, EVMA. All transitions happen on ticks.
- IDLE: on a tick with cmd_req=1, capture the command and go to S0.
- S0 → S1: drive A and FC. For iack, drive A[23:4] = all ones, A[3:1] = level, FC = 7, and treat the cycle as read with LDS only.
- S1 → S2: assert AS_N=0. For reads, assert UDS_N/LDS_N per cmd_ds. For writes, set RW=0.
- S2 → S3: for writes, DOUT = cmd_wdata and DOE=1.
- S3 → S4: for writes, assert UDS_N/LDS_N per cmd_ds.
- S4 samples the responder inputs on each tick. Priority: BERR_N=0 > DTACK_N=0 > VPA_N=0.
  - BERR_N=0: set err and go to S7.
  - DTACK_N=0: go to S5.
  - VPA_N=0: go to EWAIT.
  - None of them: stay in S4 and count one wait tick. When the count reaches TIMEOUT_TICKS, set err and go to S7.
- S5 → S6. On the tick leaving S6, latch DIN into rsp_rdata for reads, then go to S7.
- EWAIT: on the tick where ecnt==VMA_AT, assert VMA_N=0 and go to EVMA.
- EVMA: on the tick where ecnt==19 (E falling), set rsp_auto=1 and go to S7.
  - For reads, latch DIN.
  - For iack, rsp_rdata = 16'h0018 + level; DIN is ignored.
- S7: negate AS_N, UDS_N, LDS_N and VMA_N. On the next tick go to IDLE with RW=1 and DOE=0, and pulse ack for one clk32.
- Write cycles return rsp_rdata = 0.

## Timing
- Reset values: AS_N=1, UDS_N=1, LDS_N=1, RW=1, VMA_N=1, FC=0, A=0, DOUT=0, DOE=0, E=0, ack=0, rsp_*=0, ph=0, ecnt=0, state IDLE.
- Zero-wait cycle: ack pulses 16 clk32 after the accept edge. AS_N is low for 10 clk32 (S2–S6).
- Each extra S4 tick adds 2 clk32.
- A new cmd_req is considered only on ticks after ack. A req held through ack starts a new cycle at the next tick.
- res asserted mid-cycle: all outputs return to reset values immediately, no ack is issued, and the in-flight command is dropped.
- Simultaneous responder inputs resolve by the S4 priority above.

## Structure
- Package m68k_bus_pkg holds:
  - the state enum;
  - E_PERIOD=20 and E_RISE=12;
  - IACK_VEC_BASE=24;
  - FC_IACK=3'b111.
- Sub-module m68k_eclk holds the ph/ecnt divider and generates E, tick, and ecnt.

## Test plan
- Zero-wait read at 24'hE00000 (A=23'h700000), DIN=16'h1234, DTACK_N low in S4 → ack at +16 clk32, rsp_rdata=1234, rsp_err=0, AS_N low for 10 clk32.
- Write 16'hBEEF, cmd_ds=2'b01, DTACK_N asserted after 3 S4 ticks → LDS_N low only from S4, UDS_N stays high, DOUT valid from S3, ack at +22 clk32.
- Read at FFFC00 with VPA_N=0 and DTACK_N=1 → VMA_N low from ecnt 8 to cycle end, DIN=16'h00A5 latched at ecnt 19 (E falling), rsp_auto=1.
- iack level 6 answered by VPA_N → FC=7, A[3:1]=6, only LDS_N low, rsp_rdata=16'h001E, rsp_auto=1.
- BERR_N and DTACK_N low together → rsp_err=1. No response at all → ack after 250 S4 ticks with rsp_err=1.
- res pulse while in S4 → strobes high within the same clk32 and no ack. Held req is accepted on the first tick after release.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared state encoding, E-clock constants and command record for the
// 68000 bus initiator.
package m68k_bus_pkg;

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7, EWAIT, EVMA
    } bus_state_t;

    localparam int E_PERIOD      = 20;
    localparam int E_RISE        = 12;
    localparam int IACK_VEC_BASE = 24;
    localparam logic [2:0] FC_IACK = 3'b111;

    typedef struct packed {
        logic        we;
        logic        iack;
        logic [23:1] addr;
        logic [1:0]  ds;
        logic [2:0]  fc;
        logic [15:0] wdata;
    } bus_cmd_t;

    // Autovector number for an interrupt level.
    function automatic logic [15:0] iack_vector(input logic [2:0] level);
        return 16'(IACK_VEC_BASE) + {13'b0, level};
    endfunction

endpackage

// File: rtl/m68k_eclk.sv
// Half-clock phase divider and free-running 6800 E-phase counter.
module m68k_eclk
    import m68k_bus_pkg::*;
(
    input  logic       clk32,
    input  logic       res,
    output logic       tick,
    output logic [4:0] ecnt,
    output logic       e
);

    logic ph;

    always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
            ph   <= 1'b0;
            ecnt <= '0;
        end else begin
            ph <= ~ph;
            if (ph)
                ecnt <= (ecnt == 5'(E_PERIOD - 1)) ? 5'd0 : ecnt + 5'd1;
        end
    end

    assign tick = ph;
    assign e    = (ecnt >= 5'(E_RISE));

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000 bus-cycle initiator: normal asynchronous, 6800-style VPA/VMA and
// autovectored interrupt-acknowledge cycles driven from one command port.
module m68k_bus_initiator
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 250,
    parameter int VMA_AT        = 8
) (
    input  logic        clk32,
    input  logic        res,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic        cmd_iack,
    input  logic [23:1] cmd_addr,
    input  logic [1:0]  cmd_ds,
    input  logic [2:0]  cmd_fc,
    input  logic [15:0] cmd_wdata,
    output logic        ack,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_auto,
    output logic        AS_N,
    output logic        UDS_N,
    output logic        LDS_N,
    output logic        RW,
    output logic [2:0]  FC,
    output logic [23:1] A,
    output logic [15:0] DOUT,
    output logic        DOE,
    input  logic [15:0] DIN,
    input  logic        DTACK_N,
    input  logic        BERR_N,
    input  logic        VPA_N,
    output logic        VMA_N,
    output logic        E
);

    localparam int WCNT_W = $clog2(TIMEOUT_TICKS + 1);

    logic              tick;
    logic [4:0]        ecnt;
    bus_state_t        state, state_nxt;
    bus_cmd_t          cmd, cmd_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              as_nxt, uds_nxt, lds_nxt, rw_nxt, doe_nxt, vma_nxt, ack_nxt;
    logic              err_nxt, auto_nxt;
    logic [2:0]        fc_nxt;
    logic [23:1]       a_nxt;
    logic [15:0]       dout_nxt, rdata_nxt;

    m68k_eclk u_eclk (
        .clk32 (clk32),
        .res   (res),
        .tick  (tick),
        .ecnt  (ecnt),
        .e     (E)
    );

    always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
            state     <= IDLE;
            cmd       <= '0;
            wcnt      <= '0;
            AS_N      <= 1'b1;
            UDS_N     <= 1'b1;
            LDS_N     <= 1'b1;
            RW        <= 1'b1;
            VMA_N     <= 1'b1;
            FC        <= '0;
            A         <= '0;
            DOUT      <= '0;
            DOE       <= 1'b0;
            ack       <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_auto  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd       <= cmd_nxt;
            wcnt      <= wcnt_nxt;
            AS_N      <= as_nxt;
            UDS_N     <= uds_nxt;
            LDS_N     <= lds_nxt;
            RW        <= rw_nxt;
            VMA_N     <= vma_nxt;
            FC        <= fc_nxt;
            A         <= a_nxt;
            DOUT      <= dout_nxt;
            DOE       <= doe_nxt;
            ack       <= ack_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
            rsp_auto  <= auto_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        wcnt_nxt  = wcnt;
        as_nxt    = AS_N;
        uds_nxt   = UDS_N;
        lds_nxt   = LDS_N;
        rw_nxt    = RW;
        vma_nxt   = VMA_N;
        fc_nxt    = FC;
        a_nxt     = A;
        dout_nxt  = DOUT;
        doe_nxt   = DOE;
        ack_nxt   = 1'b0;
        rdata_nxt = rsp_rdata;
        err_nxt   = rsp_err;
        auto_nxt  = rsp_auto;
        if (tick) begin
            unique case (state)
                IDLE: if (cmd_req) begin
                    // An interrupt acknowledge is a lower-byte read regardless of the request.
                    cmd_nxt.we    = cmd_we & ~cmd_iack;
                    cmd_nxt.iack  = cmd_iack;
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.ds    = cmd_iack ? 2'b01 : cmd_ds;
                    cmd_nxt.fc    = cmd_fc;
                    cmd_nxt.wdata = cmd_wdata;
                    wcnt_nxt      = '0;
                    rdata_nxt     = '0;
                    err_nxt       = 1'b0;
                    auto_nxt      = 1'b0;
                    state_nxt     = S0;
                end
                S0: begin
                    a_nxt     = cmd.iack ? {20'hFFFFF, cmd.addr[3:1]} : cmd.addr;
                    fc_nxt    = cmd.iack ? FC_IACK : cmd.fc;
                    state_nxt = S1;
                end
                S1: begin
                    as_nxt = 1'b0;
                    if (cmd.we) begin
                        rw_nxt = 1'b0;
                    end else begin
                        uds_nxt = ~cmd.ds[1];
                        lds_nxt = ~cmd.ds[0];
                    end
                    state_nxt = S2;
                end
                S2: begin
                    if (cmd.we) begin
                        dout_nxt = cmd.wdata;
                        doe_nxt  = 1'b1;
                    end
                    state_nxt = S3;
                end
                S3: begin
                    if (cmd.we) begin
                        uds_nxt = ~cmd.ds[1];
                        lds_nxt = ~cmd.ds[0];
                    end
                    state_nxt = S4;
                end
                S4: begin
                    if (!BERR_N) begin
                        err_nxt   = 1'b1;
                        state_nxt = S7;
                    end else if (!DTACK_N) begin
                        state_nxt = S5;
                    end else if (!VPA_N) begin
                        state_nxt = EWAIT;
                    end else if (wcnt == WCNT_W'(TIMEOUT_TICKS - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = S7;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
                S5: state_nxt = S6;
                S6: begin
                    if (!cmd.we)
                        rdata_nxt = DIN;
                    state_nxt = S7;
                end
                EWAIT: if (ecnt == 5'(VMA_AT)) begin
                    vma_nxt   = 1'b0;
                    state_nxt = EVMA;
                end
                EVMA: if (ecnt == 5'(E_PERIOD - 1)) begin
                    auto_nxt = 1'b1;
                    if (cmd.iack)
                        rdata_nxt = iack_vector(cmd.addr[3:1]);
                    else if (!cmd.we)
                        rdata_nxt = DIN;
                    state_nxt = S7;
                end
                S7: begin
                    rw_nxt    = 1'b1;
                    doe_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
            // Every path into S7 releases the strobes on the same tick.
            if (state_nxt == S7 && state != S7) begin
                as_nxt  = 1'b1;
                uds_nxt = 1'b1;
                lds_nxt = 1'b1;
                vma_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Randomized bench for m68k_bus_initiator against a cycle-count reference model.
module tb_m68k_bus_initiator;

    localparam int TO  = 250;
    localparam int VMA = 8;

    logic        clk32 = 1'b0;
    logic        res = 1'b1;
    logic        cmd_req = 1'b0, cmd_we = 1'b0, cmd_iack = 1'b0;
    logic [23:1] cmd_addr = '0;
    logic [1:0]  cmd_ds = '0;
    logic [2:0]  cmd_fc = '0;
    logic [15:0] cmd_wdata = '0;
    logic        ack, rsp_err, rsp_auto;
    logic [15:0] rsp_rdata;
    logic        AS_N, UDS_N, LDS_N, RW, DOE, VMA_N, E;
    logic [2:0]  FC;
    logic [23:1] A;
    logic [15:0] DOUT;
    logic [15:0] DIN = '0;
    logic        DTACK_N = 1'b1, BERR_N = 1'b1, VPA_N = 1'b1;

    int total = 0;
    int bad = 0;
    int edge_n = -1;
    int rkind = 5;
    int rwait = 0;
    int rcnt = 0;

    m68k_bus_initiator #(.TIMEOUT_TICKS(TO), .VMA_AT(VMA)) dut (
        .clk32(clk32), .res(res), .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_iack(cmd_iack),
        .cmd_addr(cmd_addr), .cmd_ds(cmd_ds), .cmd_fc(cmd_fc), .cmd_wdata(cmd_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_auto(rsp_auto),
        .AS_N(AS_N), .UDS_N(UDS_N), .LDS_N(LDS_N), .RW(RW), .FC(FC), .A(A),
        .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .DTACK_N(DTACK_N), .BERR_N(BERR_N),
        .VPA_N(VPA_N), .VMA_N(VMA_N), .E(E)
    );

    always #5 clk32 = ~clk32;

    // clk32 edges since reset release; edge 0 is the first, odd edges are ticks
    always @(posedge clk32 or posedge res) begin
        if (res) edge_n <= -1;
        else     edge_n <= edge_n + 1;
    end

    // Responder: kinds 0=DTACK 1=VPA 2=BERR 3=BERR+DTACK 4=DTACK+VPA 5=silent.
    // It answers so that the response is first seen on S4 tick number rwait.
    always @(negedge clk32) begin
        if (AS_N) begin
            rcnt    <= 0;
            DTACK_N <= 1'b1;
            BERR_N  <= 1'b1;
            VPA_N   <= 1'b1;
        end else begin
            rcnt <= rcnt + 1;
            if (rcnt + 1 >= 5 + 2 * rwait) begin
                DTACK_N <= !(rkind == 0 || rkind == 3 || rkind == 4);
                VPA_N   <= !(rkind == 1 || rkind == 4);
                BERR_N  <= !(rkind == 2 || rkind == 3);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ecnt_before(input int t);
        return ((t - 1) / 2) % 20;
    endfunction

    task automatic run_txn(input int id, input bit we, input bit iack, input logic [23:1] addr,
                           input logic [1:0] ds, input logic [2:0] fc, input logic [15:0] wd,
                           input logic [15:0] din, input int kind, input int w, input int gap,
                           input bit hold_after);
        int a, s, t, t8, ack_exp, l, vma_exp, ack_at;
        int as_lo, uds_lo, lds_lo, doe_hi, rw_lo, vma_lo, e_bad;
        bit rd, err_exp, auto_exp, e_exp;
        logic [1:0]  dse;
        logic [15:0] rd_exp, rdata_got, dout_got;
        logic [23:1] a_exp, a_got;
        logic [2:0]  fc_exp, fc_got;
        logic        err_got, auto_got;
        string p;
        repeat (gap) @(negedge clk32);
        cmd_we = we; cmd_iack = iack; cmd_addr = addr; cmd_ds = ds; cmd_fc = fc;
        cmd_wdata = wd; DIN = din; rkind = kind; rwait = w; cmd_req = 1'b1;
        a = edge_n + 1;
        if (a % 2 == 0) a++;

        rd  = !we || iack;
        dse = iack ? 2'b01 : ds;
        s   = a + 10 + 2 * w;
        vma_exp = 0; err_exp = 0; auto_exp = 0; rd_exp = '0;
        case (kind)
            0, 4: begin
                ack_exp = s + 6;
                if (rd) rd_exp = din;
            end
            2, 3: begin
                ack_exp = s + 2;
                err_exp = 1;
            end
            1: begin
                t = s + 2;
                while (ecnt_before(t) != VMA) t += 2;
                t8 = t;
                t += 2;
                while (ecnt_before(t) != 19) t += 2;
                ack_exp  = t + 2;
                vma_exp  = t - t8;
                auto_exp = 1;
                if (iack)    rd_exp = 16'd24 + 16'(addr[3:1]);
                else if (rd) rd_exp = din;
            end
            default: begin
                ack_exp = a + 10 + 2 * (TO - 1) + 2;
                err_exp = 1;
            end
        endcase
        l      = ack_exp - a - 6;
        a_exp  = iack ? {20'hFFFFF, addr[3:1]} : addr;
        fc_exp = iack ? 3'd7 : fc;

        ack_at = -1; as_lo = 0; uds_lo = 0; lds_lo = 0; doe_hi = 0; rw_lo = 0; vma_lo = 0; e_bad = 0;
        rdata_got = '0; dout_got = '0; a_got = '0; fc_got = '0; err_got = 1'b0; auto_got = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk32);
            if (!AS_N)  as_lo++;
            if (!UDS_N) uds_lo++;
            if (!LDS_N) lds_lo++;
            if (DOE)    doe_hi++;
            if (!RW)    rw_lo++;
            if (!VMA_N) vma_lo++;
            e_exp = (((edge_n + 1) / 2) % 20) >= 12;
            if (E !== e_exp) e_bad++;
            if (ack) begin
                ack_at = edge_n; rdata_got = rsp_rdata; err_got = rsp_err; auto_got = rsp_auto;
                a_got = A; fc_got = FC; dout_got = DOUT;
                break;
            end
        end
        cmd_req = hold_after;

        p = $sformatf("t%0d.", id);
        check_val({p, "ack_time"}, 32'(ack_at - a), 32'(ack_exp - a));
        check_val({p, "rdata"}, 32'(rdata_got), 32'(rd_exp));
        check_val({p, "err"}, 32'(err_got), 32'(err_exp));
        check_val({p, "auto"}, 32'(auto_got), 32'(auto_exp));
        check_val({p, "as_low"}, 32'(as_lo), 32'(l));
        check_val({p, "uds_low"}, 32'(uds_lo), 32'(dse[1] ? (rd ? l : l - 4) : 0));
        check_val({p, "lds_low"}, 32'(lds_lo), 32'(dse[0] ? (rd ? l : l - 4) : 0));
        check_val({p, "doe_high"}, 32'(doe_hi), 32'(rd ? 0 : l));
        check_val({p, "rw_low"}, 32'(rw_lo), 32'(rd ? 0 : ack_exp - a - 4));
        check_val({p, "vma_low"}, 32'(vma_lo), 32'(vma_exp));
        check_val({p, "addr"}, 32'(a_got), 32'(a_exp));
        check_val({p, "fc"}, 32'(fc_got), 32'(fc_exp));
        check_val({p, "e_clock_errs"}, 32'(e_bad), 32'd0);
        if (!rd) check_val({p, "dout"}, 32'(dout_got), 32'(wd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        bit prev_hold, we, iack, hold;
        int r, kind, gap;
        logic [23:1] ra;

        repeat (3) @(negedge clk32);
        check_val("rst.as_n", 32'(AS_N), 32'd1);
        check_val("rst.uds_n", 32'(UDS_N), 32'd1);
        check_val("rst.lds_n", 32'(LDS_N), 32'd1);
        check_val("rst.rw", 32'(RW), 32'd1);
        check_val("rst.vma_n", 32'(VMA_N), 32'd1);
        check_val("rst.fc", 32'(FC), 32'd0);
        check_val("rst.a", 32'(A), 32'd0);
        check_val("rst.dout", 32'(DOUT), 32'd0);
        check_val("rst.doe", 32'(DOE), 32'd0);
        check_val("rst.e", 32'(E), 32'd0);
        check_val("rst.ack", 32'(ack), 32'd0);
        check_val("rst.rsp", 32'({rsp_rdata, rsp_err, rsp_auto}), 32'd0);
        res = 1'b0;

        // directed cases
        run_txn(1, 0, 0, 23'h700000, 2'b11, 3'd5, 16'h0000, 16'h1234, 0, 0, 0, 0);
        run_txn(2, 1, 0, 23'h001234, 2'b01, 3'd1, 16'hBEEF, 16'h5555, 0, 3, 1, 0);
        run_txn(3, 0, 0, 23'h7FFE00, 2'b11, 3'd5, 16'h0000, 16'h00A5, 1, 0, 2, 0);
        run_txn(4, 0, 1, 23'h000006, 2'b11, 3'd2, 16'h0000, 16'hDEAD, 1, 1, 0, 0);
        run_txn(5, 0, 0, 23'h000100, 2'b10, 3'd6, 16'h0000, 16'h7777, 3, 1, 1, 0);
        run_txn(6, 0, 0, 23'h000200, 2'b11, 3'd6, 16'h0000, 16'h8888, 5, 0, 0, 0);
        run_txn(7, 1, 0, 23'h0ABCDE, 2'b11, 3'd1, 16'hCAFE, 16'h0000, 4, 2, 3, 1);
        run_txn(8, 0, 0, 23'h0ABCDF, 2'b10, 3'd2, 16'h0000, 16'h4321, 0, 0, 0, 0);

        // reset while waiting in S4, request held across reset
        cmd_we = 1'b0; cmd_iack = 1'b0; cmd_addr = 23'h012345; cmd_ds = 2'b11; cmd_fc = 3'd5;
        DIN = 16'h9A9A; rkind = 5; rwait = 0; cmd_req = 1'b1;
        a = edge_n + 1;
        if (a % 2 == 0) a++;
        while (edge_n < a + 20) @(negedge clk32);
        check_val("rstmid.pre_as", 32'(AS_N), 32'd0);
        res = 1'b1;
        #1;
        check_val("rstmid.strobes", 32'({AS_N, UDS_N, LDS_N, RW, VMA_N}), 32'h1F);
        check_val("rstmid.bus", 32'({A, FC, DOE}), 32'd0);
        @(negedge clk32);
        check_val("rstmid.ack", 32'(ack), 32'd0);
        @(negedge clk32);
        res = 1'b0;
        run_txn(9, 0, 0, 23'h012345, 2'b11, 3'd5, 16'h0000, 16'h9A9A, 0, 0, 0, 0);

        prev_hold = 1'b0;
        for (int n = 0; n < 25; n++) begin
            we   = 1'($urandom_range(0, 1));
            iack = ($urandom_range(0, 5) == 0);
            ra   = 23'($urandom);
            r    = $urandom_range(0, 9);
            kind = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            gap  = prev_hold ? 0 : $urandom_range(0, 3);
            hold = (n == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            run_txn(100 + n, we, iack, ra, 2'($urandom_range(1, 3)), 3'($urandom),
                    16'($urandom), 16'($urandom), kind, $urandom_range(0, 4), gap, hold);
            prev_hold = hold;
        end

        @(negedge clk32);
        check_val("final.ack_width", 32'(ack), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
